// File: rtl/output_port_tx_if.sv
// Crossbar-to-link bundle for the credit-based transmit port.
// The master side is the crossbar/link partner; the slave side is the port itself.
interface output_port_tx_if #(
    parameter int FW = 64,
    parameter int B  = 4
);
    logic          flit_in_wr;
    logic [FW-1:0] flit_in;
    logic          port_avail;
    logic          flit_out_wr;
    logic [FW-1:0] flit_out;
    logic          flit_rel_in;
    logic [B:0]    credit_cnt;
    logic          err;

    modport master (
        output flit_in_wr, flit_in, flit_rel_in,
        input  port_avail, flit_out_wr, flit_out, credit_cnt, err
    );

    modport slave (
        input  flit_in_wr, flit_in, flit_rel_in,
        output port_avail, flit_out_wr, flit_out, credit_cnt, err
    );
endinterface

// File: rtl/output_port_tx.sv
// Credit-based link transmitter with a 2^LB-entry local FIFO; push-to-link latency 1 cycle.
// Backpressure: port_avail drops when the FIFO will be full; writes while full are dropped and flag err.
module output_port_tx #(
    parameter int FW = 64,
    parameter int B  = 4,
    parameter int LB = 2
) (
    input  logic              clk,
    input  logic              rst,
    output_port_tx_if.slave   bus
);
    localparam int         DEPTH   = 1 << LB;
    localparam logic [LB:0] DEPTH_C = (LB+1)'(DEPTH);
    localparam logic [B:0]  CMAX    = (B+1)'(1 << B);

    logic [FW-1:0] mem [DEPTH];
    logic [LB-1:0] wr_ptr;
    logic [LB-1:0] rd_ptr;
    logic [LB:0]   occ;
    logic [LB:0]   occ_next;
    logic [B:0]    credit;
    logic [B:0]    credit_next;
    logic          push;
    logic          pop;
    logic          drop;
    logic          ovf;
    logic          err_q;
    logic          avail_q;
    logic          out_wr_q;
    logic [FW-1:0] out_q;

    always_comb begin
        pop  = (occ != '0) && (credit != '0);
        push = bus.flit_in_wr && ((occ < DEPTH_C) || pop);
        drop = bus.flit_in_wr && !push;

        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase

        // A release with no pop against a full credit count means downstream returned more than it held.
        credit_next = credit;
        ovf         = 1'b0;
        case ({pop, bus.flit_rel_in})
            2'b10: credit_next = credit - 1'b1;
            2'b01: begin
                if (credit == CMAX) ovf = 1'b1;
                else                credit_next = credit + 1'b1;
            end
            default: credit_next = credit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            credit   <= CMAX;
            err_q    <= 1'b0;
            avail_q  <= 1'b1;
            out_wr_q <= 1'b0;
            out_q    <= '0;
        end else begin
            occ      <= occ_next;
            credit   <= credit_next;
            avail_q  <= (occ_next < DEPTH_C);
            out_wr_q <= pop;
            if (drop || ovf) err_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                out_q  <= mem[rd_ptr];
            end
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= bus.flit_in;
    end

    assign bus.port_avail  = avail_q;
    assign bus.flit_out_wr = out_wr_q;
    assign bus.flit_out    = out_q;
    assign bus.credit_cnt  = credit;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_output_port_tx.sv
// Bench for output_port_tx: directed scenarios plus random traffic against a queue-based reference.
module tb_output_port_tx;
    localparam int FW = 64;
    localparam int B  = 4;
    localparam int LB = 2;
    localparam int CMAX  = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_port_tx_if #(.FW(FW), .B(B)) bus ();

    output_port_tx #(.FW(FW), .B(B), .LB(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: what the link and counters should look like after each edge.
    logic [FW-1:0] exp_q[$];
    int            exp_credit;
    bit            exp_err;
    bit            exp_wr;
    logic [FW-1:0] exp_out;
    bit            exp_avail;
    logic [FW-1:0] seq;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit wr, input logic [FW-1:0] d, input bit rel, input bit r);
        bit do_pop, do_push;
        if (r) begin
            exp_q.delete();
            exp_credit = CMAX;
            exp_err    = 0;
            exp_wr     = 0;
            exp_out    = '0;
            exp_avail  = 1;
        end else begin
            do_pop  = (exp_q.size() != 0) && (exp_credit != 0);
            do_push = wr && ((exp_q.size() < DEPTH) || do_pop);
            exp_wr  = do_pop;
            if (do_pop) exp_out = exp_q.pop_front();
            if (do_push) exp_q.push_back(d);
            if (wr && !do_push) exp_err = 1;
            if (do_pop) exp_credit--;
            if (rel) exp_credit++;
            if (exp_credit > CMAX) begin
                exp_credit = CMAX;
                exp_err    = 1;
            end
            exp_avail = (exp_q.size() < DEPTH);
        end
    endtask

    task automatic cycle(input bit wr, input logic [FW-1:0] d, input bit rel, input bit r);
        rst            = r;
        bus.flit_in_wr = wr;
        bus.flit_in    = d;
        bus.flit_rel_in = rel;
        model_step(wr, d, rel, r);
        @(posedge clk);
        #1;
        check("flit_out_wr", {63'd0, bus.flit_out_wr}, {63'd0, exp_wr});
        check("flit_out", bus.flit_out, exp_out);
        check("credit_cnt", {59'd0, bus.credit_cnt}, 64'(exp_credit));
        check("port_avail", {63'd0, bus.port_avail}, {63'd0, exp_avail});
        check("err", {63'd0, bus.err}, {63'd0, exp_err});
    endtask

    task automatic push(input logic [FW-1:0] d);
        cycle(1, d, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, '0, 0, 1);
    endtask

    int wr_cnt;

    initial begin
        rst = 1'b1;
        bus.flit_in_wr  = 1'b0;
        bus.flit_in     = '0;
        bus.flit_rel_in = 1'b0;
        seq = 64'h100;
        #1;

        // Reset values
        do_reset();
        check("reset_credit", {59'd0, bus.credit_cnt}, 64'd16);
        check("reset_avail", {63'd0, bus.port_avail}, 64'd1);

        // Three flits back to back, one-cycle latency to the link
        push(64'h1);
        check("lat_none", {63'd0, bus.flit_out_wr}, 64'd0);
        push(64'h2);
        check("lat_f1", bus.flit_out, 64'h1);
        push(64'h3);
        check("lat_f2", bus.flit_out, 64'h2);
        idle(1);
        check("lat_f3", bus.flit_out, 64'h3);
        check("lat_credit", {59'd0, bus.credit_cnt}, 64'd13);
        idle(2);

        // Credit exhaustion with 20 flits, then one write while full
        do_reset();
        wr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            push(seq);
            seq++;
            wr_cnt += bus.flit_out_wr;
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            wr_cnt += bus.flit_out_wr;
        end
        check("exh_sent", 64'(wr_cnt), 64'd16);
        check("exh_credit", {59'd0, bus.credit_cnt}, 64'd0);
        check("exh_avail", {63'd0, bus.port_avail}, 64'd0);
        check("exh_err_before", {63'd0, bus.err}, 64'd0);
        push(seq); seq++;
        check("exh_err_drop", {63'd0, bus.err}, 64'd1);
        cycle(0, '0, 1, 0);
        check("rel_no_wr_yet", {63'd0, bus.flit_out_wr}, 64'd0);
        idle(1);
        check("rel_one_wr", {63'd0, bus.flit_out_wr}, 64'd1);
        idle(1);
        check("rel_only_one", {63'd0, bus.flit_out_wr}, 64'd0);

        // Credit held at 5 with pop and release every cycle
        do_reset();
        for (int i = 0; i < 11; i++) begin push(seq); seq++; end
        idle(2);
        check("c5_start", {59'd0, bus.credit_cnt}, 64'd5);
        push(seq); seq++;
        for (int i = 0; i < 8; i++) begin
            cycle(1, seq, 1, 0); seq++;
            check("c5_stream", {63'd0, bus.flit_out_wr}, 64'd1);
        end
        cycle(0, '0, 1, 0);
        check("c5_hold", {59'd0, bus.credit_cnt}, 64'd5);
        idle(2);

        // Release overflow
        do_reset();
        cycle(0, '0, 1, 0);
        check("ovf_credit", {59'd0, bus.credit_cnt}, 64'd16);
        check("ovf_err", {63'd0, bus.err}, 64'd1);
        idle(3);
        check("ovf_sticky", {63'd0, bus.err}, 64'd1);

        // Full FIFO with simultaneous push and pop wraps the pointers
        do_reset();
        for (int i = 0; i < 20; i++) begin push(seq); seq++; end
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 10; i++) begin cycle(1, seq, 1, 0); seq++; end
        check("full_pp_err", {63'd0, bus.err}, 64'd0);
        check("full_pp_avail", {63'd0, bus.port_avail}, 64'd0);
        check("full_pp_credit", {59'd0, bus.credit_cnt}, 64'd1);

        // Mid-stream reset with a release in the reset cycle
        do_reset();
        for (int i = 0; i < 6; i++) begin push(seq); seq++; end
        cycle(1, seq, 1, 1); seq++;
        check("mid_credit", {59'd0, bus.credit_cnt}, 64'd16);
        check("mid_wr", {63'd0, bus.flit_out_wr}, 64'd0);
        check("mid_avail", {63'd0, bus.port_avail}, 64'd1);
        idle(2);
        check("mid_empty", {63'd0, bus.flit_out_wr}, 64'd0);

        // Randomized traffic with a loosely behaved allocator and downstream
        for (int i = 0; i < 2000; i++) begin
            bit wr, rel, r;
            wr  = (bus.port_avail || ($urandom_range(0, 7) == 0)) && ($urandom_range(0, 2) != 0);
            rel = ((exp_credit < CMAX) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 199) == 0);
            r   = ($urandom_range(0, 299) == 0);
            cycle(wr, {$urandom, $urandom}, rel, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
